// File: rtl/pc_gen.sv
// Fetch PC generator: boot/run/trap sequencing, branch/jump redirect, misaligned-target trap.
// Optional macro PC_COMPRESSED_EN enables 2-byte increments (Is_rvc) and 2-byte target alignment.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Stall,
  input  logic            Fetch_ready,
  input  logic            Branch,
  input  logic [2:0]      Br_funct3,
  input  logic            Eq,
  input  logic            Lt,
  input  logic            Ltu,
  input  logic            Jal,
  input  logic            Jalr,
  input  logic [XLEN-1:0] Ex_pc,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Imm,
  input  logic            Is_rvc,
  output logic [XLEN-1:0] PC_o,
  output logic            PC_valid,
  output logic            Redirect_o,
  output logic            Exc_o
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redir_q, redir_d;
  logic            exc_q, exc_d;

  logic            cond, taken, redirect, misaligned;
  logic [XLEN-1:0] jalr_sum, target, inc;

  always_comb begin
    cond = 1'b0;
    unique case (Br_funct3)
      3'b000:  cond = Eq;
      3'b001:  cond = !Eq;
      3'b100:  cond = Lt;
      3'b101:  cond = !Lt;
      3'b110:  cond = Ltu;
      3'b111:  cond = !Ltu;
      default: cond = 1'b0;
    endcase
  end

  assign taken    = Branch & cond;
  assign redirect = Jalr | Jal | taken;
  assign jalr_sum = Rs1 + Imm;
  assign target   = Jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (Ex_pc + Imm);

`ifdef PC_COMPRESSED_EN
  assign inc        = Is_rvc ? XLEN'(2) : XLEN'(4);
  assign misaligned = target[0];
`else
  logic unused_rvc;
  assign unused_rvc = Is_rvc;
  assign inc        = XLEN'(4);
  assign misaligned = |target[1:0];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = 1'b0;
    exc_d   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      TRAP: state_d = RUN;
      RUN: begin
        if (redirect && misaligned) begin
          state_d = TRAP;
          pc_d    = TRAP_VEC;
          redir_d = 1'b1;
          exc_d   = 1'b1;
        end else if (redirect) begin
          pc_d    = target;
          redir_d = 1'b1;
        end else if (Fetch_ready && !Stall) begin
          pc_d    = pc_q + inc;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      redir_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      exc_q   <= exc_d;
    end
  end

  assign PC_o       = pc_q;
  assign PC_valid   = (state_q == RUN);
  assign Redirect_o = redir_q;
  assign Exc_o      = exc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic against a behavioural model.
module tb_pc_gen;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Fetch_ready, Branch, Eq, Lt, Ltu, Jal, Jalr, Is_rvc;
  logic [2:0]  Br_funct3;
  logic [31:0] Ex_pc, Rs1, Imm;
  logic [31:0] PC_o;
  logic        PC_valid, Redirect_o, Exc_o;

  int errors = 0;
  int checks = 0;

  pc_gen dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Fetch_ready(Fetch_ready),
    .Branch(Branch), .Br_funct3(Br_funct3), .Eq(Eq), .Lt(Lt), .Ltu(Ltu),
    .Jal(Jal), .Jalr(Jalr), .Ex_pc(Ex_pc), .Rs1(Rs1), .Imm(Imm), .Is_rvc(Is_rvc),
    .PC_o(PC_o), .PC_valid(PC_valid), .Redirect_o(Redirect_o), .Exc_o(Exc_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        redir;
    logic        exc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: "mode" 0 = booting, 1 = fetching, 2 = recovering from a trap
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'h0;
  string       cur_tag = "init";

  function automatic bit model_cond(input logic [2:0] f, input logic eq, input logic lt, input logic ltu);
    case (f)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 0;
    endcase
  endfunction

  task automatic cyc();
    exp_t e;
    logic [31:0] tgt;
    bit tk, bad;
    e.redir = 0;
    e.exc   = 0;
    if (!Rst_n) begin
      m_mode = 0;
      m_pc   = RESET_VEC;
    end else if (m_mode != 1) begin
      m_mode = 1;
    end else begin
      tk = Branch && model_cond(Br_funct3, Eq, Lt, Ltu);
      if (Jalr)     tgt = (Rs1 + Imm) & 32'hFFFF_FFFE;
      else          tgt = Ex_pc + Imm;
`ifdef PC_COMPRESSED_EN
      bad = (tgt % 2) != 0;
`else
      bad = (tgt % 4) != 0;
`endif
      if (Jalr || Jal || tk) begin
        e.redir = 1;
        if (bad) begin
          e.exc  = 1;
          m_pc   = TRAP_VEC;
          m_mode = 2;
        end else begin
          m_pc = tgt;
        end
      end else if (Fetch_ready && !Stall) begin
`ifdef PC_COMPRESSED_EN
        m_pc = m_pc + (Is_rvc ? 32'd2 : 32'd4);
`else
        m_pc = m_pc + 32'd4;
`endif
      end
    end
    e.pc    = m_pc;
    e.valid = (m_mode == 1);
    e.tag   = cur_tag;
    exp_q.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  task automatic clear_ctl();
    Stall = 0; Branch = 0; Br_funct3 = 3'd0; Eq = 0; Lt = 0; Ltu = 0;
    Jal = 0; Jalr = 0; Ex_pc = '0; Rs1 = '0; Imm = '0; Is_rvc = 0;
  endtask

  // Monitor: every cycle the DUT presents a registered result; compare against the oldest expectation
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (PC_o !== e.pc) begin
        errors++;
        $display("FAIL %s pc: got %h want %h", e.tag, PC_o, e.pc);
      end
      checks++;
      if (PC_valid !== e.valid) begin
        errors++;
        $display("FAIL %s valid: got %b want %b", e.tag, PC_valid, e.valid);
      end
      checks++;
      if (Redirect_o !== e.redir) begin
        errors++;
        $display("FAIL %s redirect: got %b want %b", e.tag, Redirect_o, e.redir);
      end
      checks++;
      if (Exc_o !== e.exc) begin
        errors++;
        $display("FAIL %s exc: got %b want %b", e.tag, Exc_o, e.exc);
      end
    end
  end

  initial begin
    clear_ctl();
    Rst_n = 0; Fetch_ready = 0;
    cur_tag = "reset";
    cyc(); cyc();
    Rst_n = 1; Fetch_ready = 1;
    cur_tag = "boot_seq";
    cyc(); cyc(); cyc();

    cur_tag = "bne_stalled";
    Ex_pc = 32'h40; Imm = 32'h20; Branch = 1; Br_funct3 = 3'b001; Eq = 0; Stall = 1;
    cyc();
    clear_ctl(); cur_tag = "after_bne";
    cyc();

    cur_tag = "jalr_odd";
    Jalr = 1; Rs1 = 32'h1001; Imm = 32'h2;
    cyc();
    clear_ctl(); cur_tag = "after_jalr";
    Jal = 1; Ex_pc = 32'h8; Imm = 32'h1;   // ignored if trapping; otherwise misaligned again
    cyc();
    clear_ctl();
    cyc(); cyc();

    cur_tag = "jal_vs_branch";
    Jal = 1; Branch = 1; Br_funct3 = 3'b000; Eq = 1; Imm = 32'h8; Ex_pc = 32'h10; Rs1 = 32'h500;
    cyc();
    clear_ctl(); cyc();

    cur_tag = "wrap";
    Jal = 1; Ex_pc = 32'hFFFF_FFF0; Imm = 32'hC;
    cyc();
    clear_ctl(); Fetch_ready = 1;
    cyc();
    Fetch_ready = 0; cur_tag = "hold";
    cyc(); cyc();
    Fetch_ready = 1;
    cur_tag = "branch_codes";
    for (int f = 0; f < 8; f++) begin
      Branch = 1; Br_funct3 = 3'(f); Eq = f[0]; Lt = f[1]; Ltu = !f[0];
      Ex_pc = 32'h200 + 32'(f * 16); Imm = 32'h40;
      cyc();
    end
    clear_ctl();

    cur_tag = "reset_vs_branch";
    Branch = 1; Br_funct3 = 3'b000; Eq = 1; Ex_pc = 32'h80; Imm = 32'h10; Rst_n = 0;
    cyc();
    clear_ctl(); Rst_n = 1;
    cyc(); cyc();

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      Rst_n       = ($urandom_range(0, 59) != 0);
      Stall       = ($urandom_range(0, 3) == 0);
      Fetch_ready = ($urandom_range(0, 3) != 0);
      Branch      = ($urandom_range(0, 5) == 0);
      Br_funct3   = 3'($urandom_range(0, 7));
      Eq          = 1'($urandom); Lt = 1'($urandom); Ltu = 1'($urandom);
      Jal         = ($urandom_range(0, 11) == 0);
      Jalr        = ($urandom_range(0, 11) == 0);
      Ex_pc       = $urandom & 32'hFFFF_FFFC;
      Rs1         = $urandom;
      Imm         = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        Imm = Imm & 32'hFFFF_FFFC;
        Rs1 = Rs1 & 32'hFFFF_FFFC;
      end
      Is_rvc      = 1'($urandom);
      cyc();
    end
    clear_ctl();
    cyc();

    repeat (3) @(posedge Clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and operand width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, fetch address after a misaligned-target trap.
REQ-004 SHALL have port Clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port Stall  in  1  hold the current PC.
REQ-007 SHALL have port Fetch_ready  in  1  fetch stage accepts PC_o this cycle.
REQ-008 SHALL have port Branch  in  1  execute-stage conditional branch.
REQ-009 SHALL have port Br_funct3  in  3  branch type.
REQ-010 SHALL have ports Eq, Lt, Ltu  in  1 each  ALU compare flags for the branch.
REQ-011 SHALL have ports Jal, Jalr  in  1 each  execute-stage jump.
REQ-012 SHALL have port Ex_pc  in  XLEN  PC of the execute-stage instruction.
REQ-013 SHALL have port Rs1  in  XLEN  JALR base.
REQ-014 SHALL have port Imm  in  XLEN  sign-extended byte offset.
REQ-015 SHALL have port Is_rvc  in  1  current fetch is a 16-bit instruction (used only under PC_COMPRESSED_EN).
REQ-016 SHALL have port PC_o  out  XLEN  registered fetch address.
REQ-017 SHALL have port PC_valid  out  1  PC_o is valid for fetch.
REQ-018 SHALL have port Redirect_o  out  1  one-cycle flush pulse for younger instructions.
REQ-019 SHALL have port Exc_o  out  1  one-cycle misaligned-target exception pulse.

Function
REQ-020 SHALL implement FSM states BOOT, RUN, TRAP; BOOT -> RUN after one cycle; RUN -> TRAP on misaligned taken target; TRAP -> RUN after one cycle.
REQ-021 SHALL drive PC_valid high only in RUN.
REQ-022 SHALL evaluate taken = Branch & cond, cond by Br_funct3: 000 Eq, 001 !Eq, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu, 010/011 never taken.
REQ-023 SHALL compute targets: branch and JAL = Ex_pc + Imm; JALR = (Rs1 + Imm) with bit 0 cleared; priority Jalr > Jal > taken branch.
REQ-024 SHALL treat a target as misaligned when bits [1:0] != 0 (bit [1] ignored under PC_COMPRESSED_EN).
REQ-025 SHALL, in RUN, apply next-state priority: misaligned redirect > redirect > advance > hold.
REQ-026 SHALL, on aligned redirect, load the target on the next edge and pulse Redirect_o for that edge's cycle, regardless of Stall or Fetch_ready.
REQ-027 SHALL, on misaligned redirect, load TRAP_VEC, enter TRAP, and pulse Exc_o and Redirect_o for one cycle.
REQ-028 SHALL advance PC_o by the increment only when PC_valid & Fetch_ready & !Stall; otherwise hold.
REQ-029 SHALL perform all PC arithmetic modulo 2^XLEN (0xFFFF_FFFC + 4 = 0x0000_0000).
REQ-030 SHALL ignore Branch/Jal/Jalr in BOOT and TRAP.

Reset
REQ-031 SHALL, on Rst_n low at a clock edge, set PC_o = RESET_VEC, state = BOOT, PC_valid = 0, Redirect_o = 0, Exc_o = 0, overriding any redirect or trap in progress.

Configuration
REQ-032 SHALL support macro PC_COMPRESSED_EN: defined -> increment 2 when Is_rvc = 1 else 4, 2-byte target alignment; undefined -> Is_rvc ignored, increment always 4, 4-byte alignment.

Verification
REQ-033 SHALL cover: reset, then 3 cycles with Fetch_ready = 1 -> PC_valid 0 in cycle 1, then PC_o 0x0, 0x4.
REQ-034 SHALL cover: Ex_pc = 0x40, Imm = 0x20, Branch = 1, Br_funct3 = 001, Eq = 0, Stall = 1 -> PC_o = 0x60 next cycle, Redirect_o = 1 for one cycle.
REQ-035 SHALL cover: Jalr = 1, Rs1 = 0x1001, Imm = 0x2 -> PC_o = 0x1002; without the macro, Exc_o pulse and PC_o = 0x100, PC_valid low for one cycle.
REQ-036 SHALL cover: Jal = 1 and Branch taken simultaneously, Imm = 0x8, Ex_pc = 0x10 -> PC_o = 0x18 via the JAL path.
REQ-037 SHALL cover: PC_o = 0xFFFF_FFFC with an advance -> PC_o = 0x0; Fetch_ready = 0 -> PC_o held.
REQ-038 SHALL cover: Rst_n low in the same cycle as a taken branch -> PC_o = RESET_VEC, Redirect_o = 0.
